uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small TX FIFO.
//
// Bytes written with `start` are queued. The frame engine pops the head
// whenever it is idle or finishing a frame, so queued frames go out with no
// idle gap between them. Each frame latches its timing and format inputs
// when it begins, so later changes to those inputs only affect later frames.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : parity bit supported (parity_en / parity_odd active)
//   undefined : frames never carry parity; parity_en / parity_odd ignored
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   clks_per_bit  bit period in clk cycles (values below 2 act as 2)
//   data          byte to enqueue
//   start         enqueue strobe, one entry per cycle while high
//   parity_en     append parity bit (only with UART_TX_PARITY_EN)
//   parity_odd    1 = odd parity, 0 = even parity
//   two_stop      1 = two stop bits, 0 = one stop bit
//   UART_line     serial output, idles high
//   busy          frame in flight or FIFO non-empty
//   full          FIFO holds DEPTH entries
//   overrun       one-cycle pulse after a push was dropped on a full FIFO
//   done          one-cycle pulse on the last cycle of each frame
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | one or two stop bits (high)
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     clks_per_bit,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 UART_line,
    output logic                 busy,
    output logic                 full,
    output logic                 overrun,
    output logic                 done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 line_q, line_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`else
    logic                 unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    logic             push, pop, empty, bit_end, frame_end;
    logic [CNT_W-1:0] cpb_eff;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    // A drop is decided on the registered full flag, so a same-cycle pop
    // never rescues a push into a full FIFO.
    assign push    = start && !full;
    assign cpb_eff = (clks_per_bit < CNT_W'(2)) ? CNT_W'(2) : clks_per_bit;
    assign bit_end = (cnt_q == '0);

    // FIFO storage carries no reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            period_q   <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            line_q     <= line_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign frame_end = (state_q == S_STOP) && bit_end && (!stop2_q || stop_idx_q);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        cnt_d      = cnt_q;
        period_d   = period_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? period_q - CNT_W'(1) : cnt_q - CNT_W'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d   = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame start: take the head byte and snapshot the per-frame config.
        if (pop) begin
            state_d    = S_START;
            period_d   = cpb_eff;
            cnt_d      = cpb_eff - CNT_W'(1);
            shift_d    = fifo_mem[rd_ptr_q];
            bit_idx_d  = '0;
            stop2_d    = two_stop;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_d   = parity_en;
            par_bit_d  = (^fifo_mem[rd_ptr_q]) ^ parity_odd;
`endif
        end
    end

    // Line and done are registered from the current state, so both lag the
    // state by one cycle and stay aligned with each other.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = par_bit_q;
`endif
            default:  line_d = 1'b1;
        endcase
        done_d    = frame_end;
        overrun_d = start && full;
    end

    assign UART_line = line_q;
    assign overrun   = overrun_q;
    assign done      = done_q;
    // done_q keeps busy high through the last stop-bit cycle on the line.
    assign busy      = (state_q != S_IDLE) || !empty || done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    logic        clk;
    logic        rst;
    logic [15:0] clks_per_bit;
    logic [7:0]  data;
    logic        start;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic        UART_line;
    logic        busy;
    logic        full;
    logic        overrun;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    logic line_cap [0:255];
    logic done_cap [0:255];
    logic busy_cap [0:255];
    logic ovr_cap  [0:255];
    logic full_cap [0:255];
    logic [7:0] push_vals [0:7];

    uart_tx_fifo #(.DATA_BITS(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clks_per_bit(clks_per_bit), .data(data),
        .start(start), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .UART_line(UART_line), .busy(busy), .full(full),
        .overrun(overrun), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "tb_uart_tx_fifo timeout");
    end

    // Sample index s is taken at the falling edge after edge k+s, where k is
    // the edge that samples the first start.
    task automatic capture(input int n);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            line_cap[s] = UART_line;
            done_cap[s] = done;
            busy_cap[s] = busy;
            ovr_cap[s]  = overrun;
            full_cap[s] = full;
        end
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            data  = push_vals[i];
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clks_per_bit = 16'd4;
        data = 8'h00;
        start = 1'b0;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        #23;
        tests_run++;
        if (UART_line !== 1'b1) begin tests_failed++; $display("FAIL reset_line: got %b required 1", UART_line); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b required 0", full); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b required 0", done); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [9:0] fr;
        int dcount;
        fr = 10'b1101001010;   // 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1
        clks_per_bit = 16'd4;
        push_vals[0] = 8'hA5;
        @(negedge clk);
        fork
            push_seq(1);
            capture(46);
        join
        tests_run++;
        if (busy_cap[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_push: got %b required 1", busy_cap[0]); end
        tests_run++;
        if (line_cap[1] !== 1'b1) begin tests_failed++; $display("FAIL basic_latency_idle: got %b required 1", line_cap[1]); end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                tests_run++;
                if (line_cap[2 + b*4 + c] !== fr[b]) begin
                    tests_failed++;
                    $display("FAIL basic_line bit %0d cycle %0d: got %b required %b", b, c, line_cap[2 + b*4 + c], fr[b]);
                end
            end
        end
        dcount = 0;
        for (int s = 0; s < 46; s++) if (done_cap[s] === 1'b1) dcount++;
        tests_run++;
        if (dcount != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d required 1", dcount); end
        tests_run++;
        if (done_cap[41] !== 1'b1) begin tests_failed++; $display("FAIL basic_done_pos: got %b required 1 at sample 41", done_cap[41]); end
        tests_run++;
        if (busy_cap[41] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_at_done: got %b required 1", busy_cap[41]); end
        tests_run++;
        if (busy_cap[42] !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after_done: got %b required 0", busy_cap[42]); end
        tests_run++;
        if (line_cap[43] !== 1'b1) begin tests_failed++; $display("FAIL basic_line_idle: got %b required 1", line_cap[43]); end
        wait_idle();
    endtask

    task automatic test_parity();
        logic [7:0] pv [0:2];
        logic       po [0:2];
        logic       pb [0:2];
        int dcount;
        pv[0] = 8'hA5; po[0] = 1'b0; pb[0] = 1'b0;
        pv[1] = 8'hA5; po[1] = 1'b1; pb[1] = 1'b1;
        pv[2] = 8'h07; po[2] = 1'b0; pb[2] = 1'b1;
        clks_per_bit = 16'd2;
        parity_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            parity_odd = po[t];
            push_vals[0] = pv[t];
            @(negedge clk);
            fork
                push_seq(1);
                capture(28);
            join
            dcount = 0;
            for (int s = 0; s < 28; s++) if (done_cap[s] === 1'b1) dcount++;
            tests_run++;
            if (dcount != 1) begin tests_failed++; $display("FAIL parity_done_count case %0d: got %0d required 1", t, dcount); end
`ifdef UART_TX_PARITY_EN
            tests_run++;
            if (line_cap[20] !== pb[t] || line_cap[21] !== pb[t]) begin
                tests_failed++;
                $display("FAIL parity_bit case %0d: got %b%b required %b%b", t, line_cap[20], line_cap[21], pb[t], pb[t]);
            end
            tests_run++;
            if (line_cap[22] !== 1'b1) begin tests_failed++; $display("FAIL parity_stop case %0d: got %b required 1", t, line_cap[22]); end
            tests_run++;
            if (done_cap[23] !== 1'b1) begin tests_failed++; $display("FAIL parity_done_pos case %0d: got %b required 1 at 23", t, done_cap[23]); end
`else
            tests_run++;
            if (line_cap[20] !== 1'b1 || line_cap[21] !== 1'b1) begin
                tests_failed++;
                $display("FAIL noparity_stop case %0d: got %b%b required 11", t, line_cap[20], line_cap[21]);
            end
            tests_run++;
            if (done_cap[21] !== 1'b1) begin tests_failed++; $display("FAIL noparity_done_pos case %0d: got %b required 1 at 21", t, done_cap[21]); end
`endif
            wait_idle();
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr;
        int dcount;
        int ocount;
        push_vals[0] = 8'h11; push_vals[1] = 8'h22; push_vals[2] = 8'h33;
        push_vals[3] = 8'h44; push_vals[4] = 8'h55; push_vals[5] = 8'h66;
        clks_per_bit = 16'd2;
        @(negedge clk);
        fork
            push_seq(6);
            capture(106);
        join
        tests_run++;
        if (full_cap[3] !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_early: got %b required 0", full_cap[3]); end
        tests_run++;
        if (full_cap[4] !== 1'b1) begin tests_failed++; $display("FAIL b2b_full: got %b required 1", full_cap[4]); end
        tests_run++;
        if (ovr_cap[5] !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun_pos: got %b required 1 at 5", ovr_cap[5]); end
        ocount = 0;
        dcount = 0;
        for (int s = 0; s < 106; s++) begin
            if (ovr_cap[s] === 1'b1) ocount++;
            if (done_cap[s] === 1'b1) dcount++;
        end
        tests_run++;
        if (ocount != 1) begin tests_failed++; $display("FAIL b2b_overrun_count: got %0d required 1", ocount); end
        tests_run++;
        if (dcount != 5) begin tests_failed++; $display("FAIL b2b_done_count: got %0d required 5", dcount); end
        for (int j = 0; j < 5; j++) begin
            fr = {1'b1, push_vals[j], 1'b0};
            for (int b = 0; b < 10; b++) begin
                tests_run++;
                if (line_cap[2 + 20*j + 2*b] !== fr[b] || line_cap[3 + 20*j + 2*b] !== fr[b]) begin
                    tests_failed++;
                    $display("FAIL b2b_line frame %0d bit %0d: got %b%b required %b", j, b,
                             line_cap[2 + 20*j + 2*b], line_cap[3 + 20*j + 2*b], fr[b]);
                end
            end
            tests_run++;
            if (done_cap[21 + 20*j] !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_pos frame %0d: got %b required 1", j, done_cap[21 + 20*j]); end
        end
        tests_run++;
        if (busy_cap[102] !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: got %b required 0", busy_cap[102]); end
        wait_idle();
    endtask

    task automatic test_two_stop_timing();
        logic [10:0] fr;
        int dcount;
        fr = {2'b11, 8'h3C, 1'b0};
        clks_per_bit = 16'd1;
        two_stop = 1'b1;
        push_vals[0] = 8'h3C;
        @(negedge clk);
        fork
            push_seq(1);
            capture(26);
            begin
                repeat (8) @(negedge clk);
                clks_per_bit = 16'd9;
                two_stop = 1'b0;
            end
        join
        for (int b = 0; b < 11; b++) begin
            tests_run++;
            if (line_cap[2 + 2*b] !== fr[b] || line_cap[3 + 2*b] !== fr[b]) begin
                tests_failed++;
                $display("FAIL two_stop_line bit %0d: got %b%b required %b", b, line_cap[2 + 2*b], line_cap[3 + 2*b], fr[b]);
            end
        end
        dcount = 0;
        for (int s = 0; s < 26; s++) if (done_cap[s] === 1'b1) dcount++;
        tests_run++;
        if (dcount != 1) begin tests_failed++; $display("FAIL two_stop_done_count: got %0d required 1", dcount); end
        tests_run++;
        if (done_cap[23] !== 1'b1) begin tests_failed++; $display("FAIL two_stop_done_pos: got %b required 1 at 23", done_cap[23]); end
        tests_run++;
        if (busy_cap[24] !== 1'b0) begin tests_failed++; $display("FAIL two_stop_busy_end: got %b required 0", busy_cap[24]); end
        wait_idle();
        clks_per_bit = 16'd4;
        two_stop = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int dcount;
        int bcount;
        int lcount;
        push_vals[0] = 8'h08; push_vals[1] = 8'h55; push_vals[2] = 8'h66;
        clks_per_bit = 16'd4;
        @(negedge clk);
        fork
            push_seq(3);
            capture(20);
        join
        tests_run++;
        if (line_cap[14] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_data_bit2: got %b required 0", line_cap[14]); end
        tests_run++;
        if (line_cap[18] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_data_bit3: got %b required 1", line_cap[18]); end
        tests_run++;
        if (busy_cap[19] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: got %b required 1", busy_cap[19]); end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (UART_line !== 1'b1) begin tests_failed++; $display("FAIL rstmid_line: got %b required 1", UART_line); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL rstmid_full: got %b required 0", full); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        capture(80);
        dcount = 0;
        bcount = 0;
        lcount = 0;
        for (int s = 0; s < 80; s++) begin
            if (done_cap[s] !== 1'b0) dcount++;
            if (busy_cap[s] !== 1'b0) bcount++;
            if (line_cap[s] !== 1'b1) lcount++;
        end
        tests_run++;
        if (dcount != 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d pulses required 0", dcount); end
        tests_run++;
        if (bcount != 0) begin tests_failed++; $display("FAIL rstmid_no_busy: got %0d busy cycles required 0", bcount); end
        tests_run++;
        if (lcount != 0) begin tests_failed++; $display("FAIL rstmid_line_idle: got %0d low cycles required 0", lcount); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_two_stop_timing();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
